// File: rtl/cpu_phase_ctrl_pkg.sv
// cpu_phase_ctrl_pkg
//   Phase state codes and PHASE width shared by the phase sequencer and any
//   debug/monitor block that decodes PHASE, so all agree on the encoding.
//   Codes 110/111 are unused; the sequencer treats them as illegal and
//   returns to IDLE.
package cpu_phase_ctrl_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE = 3'b000,
        ST_FT   = 3'b001,
        ST_DC   = 3'b010,
        ST_EX   = 3'b011,
        ST_WB   = 3'b100,
        ST_HALT = 3'b101
    } phase_t;

endpackage

// File: rtl/cpu_phase_ctrl.sv
// cpu_phase_ctrl
//   Central phase sequencer for the multi-cycle core. It walks the datapath
//   through FT -> DC -> EX -> (WB) with exactly one phase enable per cycle,
//   handles run / single-step / stop / halt / memory-wait control, and counts
//   retired instructions.
//
// Ports
//   CLK, RST              core clock; asynchronous active-high reset
//   RUN, STEP             start free-running / single-instruction execution
//                         (sampled in IDLE, RUN has priority)
//   STOP                  return to IDLE at the next instruction boundary
//   MEM_RDY               instruction memory ready; FT stretches while low
//   WB_REQ, HALT_REQ      instruction attributes, sampled in EX
//   CLR_HALT              leave HALT
//   EN_FT/DC/EX/WB        one-hot phase enables
//   PHASE                 current state code
//   BUSY, HALTED          state summaries
//   INSTR_CNT             retired-instruction count (wraps)
module cpu_phase_ctrl
    import cpu_phase_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RUN,
    input  logic               STEP,
    input  logic               STOP,
    input  logic               MEM_RDY,
    input  logic               WB_REQ,
    input  logic               HALT_REQ,
    input  logic               CLR_HALT,
    output logic               EN_FT,
    output logic               EN_DC,
    output logic               EN_EX,
    output logic               EN_WB,
    output logic [PHASE_W-1:0] PHASE,
    output logic               BUSY,
    output logic               HALTED,
    output logic [CNT_W-1:0]   INSTR_CNT
);

    phase_t state;
    logic   step_mode;
    logic   stop_pend;
    logic   in_instr;
    logic   retire_to_idle;

    assign in_instr       = (state == ST_FT) || (state == ST_DC) ||
                            (state == ST_EX) || (state == ST_WB);
    // A STOP arriving on the retire edge itself counts as well as a pending one.
    assign retire_to_idle = step_mode || stop_pend || STOP;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            step_mode <= 1'b0;
            stop_pend <= 1'b0;
            INSTR_CNT <= '0;
        end else begin
            // Remember a STOP seen mid-instruction; later assignments below
            // clear it again when IDLE/HALT exit paths are taken.
            if (STOP && in_instr)
                stop_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (RUN) begin
                        state     <= ST_FT;
                        step_mode <= 1'b0;
                    end else if (STEP) begin
                        state     <= ST_FT;
                        step_mode <= 1'b1;
                    end
                end
                ST_FT: begin
                    if (MEM_RDY)
                        state <= ST_DC;
                end
                ST_DC: begin
                    state <= ST_EX;
                end
                ST_EX: begin
                    if (HALT_REQ) begin
                        // HALT itself counts as retired.
                        state     <= ST_HALT;
                        INSTR_CNT <= INSTR_CNT + CNT_W'(1);
                    end else if (WB_REQ) begin
                        state <= ST_WB;
                    end else begin
                        INSTR_CNT <= INSTR_CNT + CNT_W'(1);
                        if (retire_to_idle) begin
                            state     <= ST_IDLE;
                            step_mode <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            state <= ST_FT;
                        end
                    end
                end
                ST_WB: begin
                    INSTR_CNT <= INSTR_CNT + CNT_W'(1);
                    if (retire_to_idle) begin
                        state     <= ST_IDLE;
                        step_mode <= 1'b0;
                        stop_pend <= 1'b0;
                    end else begin
                        state <= ST_FT;
                    end
                end
                ST_HALT: begin
                    if (CLR_HALT) begin
                        state     <= ST_IDLE;
                        step_mode <= 1'b0;
                        stop_pend <= 1'b0;
                    end
                end
                default: begin
                    // Illegal codes recover to a clean IDLE.
                    state     <= ST_IDLE;
                    step_mode <= 1'b0;
                    stop_pend <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decode straight from the state flops so they line up with PHASE.
    assign EN_FT  = (state == ST_FT);
    assign EN_DC  = (state == ST_DC);
    assign EN_EX  = (state == ST_EX);
    assign EN_WB  = (state == ST_WB);
    assign PHASE  = state;
    assign BUSY   = in_instr;
    assign HALTED = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// tb_cpu_phase_ctrl
//   Directed-vector bench for cpu_phase_ctrl. A second instance with a 4-bit
//   counter shares all inputs so counter wrap is reached in few cycles.
module tb_cpu_phase_ctrl;

    localparam logic [2:0] P_IDLE = 3'b000;
    localparam logic [2:0] P_FT   = 3'b001;
    localparam logic [2:0] P_DC   = 3'b010;
    localparam logic [2:0] P_EX   = 3'b011;
    localparam logic [2:0] P_WB   = 3'b100;
    localparam logic [2:0] P_HALT = 3'b101;

    // enable vectors as {EN_FT, EN_DC, EN_EX, EN_WB}
    localparam logic [3:0] E_NONE = 4'b0000;
    localparam logic [3:0] E_FT   = 4'b1000;
    localparam logic [3:0] E_DC   = 4'b0100;
    localparam logic [3:0] E_EX   = 4'b0010;
    localparam logic [3:0] E_WB   = 4'b0001;

    logic CLK = 1'b0;
    logic RST, RUN, STEP, STOP, MEM_RDY, WB_REQ, HALT_REQ, CLR_HALT;
    logic EN_FT, EN_DC, EN_EX, EN_WB, BUSY, HALTED;
    logic [2:0]  PHASE;
    logic [15:0] INSTR_CNT;
    logic s_en_ft, s_en_dc, s_en_ex, s_en_wb, s_busy, s_halted;
    logic [2:0]  s_phase;
    logic [3:0]  s_cnt;

    int nvec = 0;
    int nerr = 0;
    int exp_cnt = 0;

    always #5 CLK = ~CLK;

    cpu_phase_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .STOP(STOP),
        .MEM_RDY(MEM_RDY), .WB_REQ(WB_REQ), .HALT_REQ(HALT_REQ),
        .CLR_HALT(CLR_HALT), .EN_FT(EN_FT), .EN_DC(EN_DC), .EN_EX(EN_EX),
        .EN_WB(EN_WB), .PHASE(PHASE), .BUSY(BUSY), .HALTED(HALTED),
        .INSTR_CNT(INSTR_CNT)
    );

    cpu_phase_ctrl #(.CNT_W(4)) dut_small (
        .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .STOP(STOP),
        .MEM_RDY(MEM_RDY), .WB_REQ(WB_REQ), .HALT_REQ(HALT_REQ),
        .CLR_HALT(CLR_HALT), .EN_FT(s_en_ft), .EN_DC(s_en_dc), .EN_EX(s_en_ex),
        .EN_WB(s_en_wb), .PHASE(s_phase), .BUSY(s_busy), .HALTED(s_halted),
        .INSTR_CNT(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Phase, one-hot enables, BUSY/HALTED and both counters in one go.
    task automatic chk_st(input string tag, input logic [2:0] ph, input logic [3:0] en);
        chk({tag, ".phase"}, 32'(PHASE), 32'(ph));
        chk({tag, ".en"}, 32'({EN_FT, EN_DC, EN_EX, EN_WB}), 32'(en));
        chk({tag, ".busy"}, 32'(BUSY), 32'(en != E_NONE));
        chk({tag, ".halted"}, 32'(HALTED), 32'(ph == P_HALT));
        chk({tag, ".cnt"}, 32'(INSTR_CNT), 32'(exp_cnt & 32'hFFFF));
        chk({tag, ".cnt4"}, 32'(s_cnt), 32'(exp_cnt & 32'hF));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [3:0] run_en [8];
        run_en = '{E_FT, E_DC, E_EX, E_WB, E_FT, E_DC, E_EX, E_FT};

        RST = 1'b1; RUN = 0; STEP = 0; STOP = 0; MEM_RDY = 0;
        WB_REQ = 0; HALT_REQ = 0; CLR_HALT = 0;
        #12 RST = 1'b0;
        tick();
        chk_st("reset", P_IDLE, E_NONE);

        // Free run, first instruction with WB, second without.
        RUN = 1; MEM_RDY = 1; WB_REQ = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 4) exp_cnt = 1;
            if (i == 7) exp_cnt = 2;
            chk_st($sformatf("run%0d", i), (i == 3) ? P_WB :
                   (run_en[i] == E_FT) ? P_FT : (run_en[i] == E_DC) ? P_DC : P_EX,
                   run_en[i]);
            if (i == 3) WB_REQ = 0;
        end

        // STOP pulsed during DC: instruction finishes through WB, then IDLE.
        RUN = 0;
        tick(); chk_st("stop_dc", P_DC, E_DC);
        STOP = 1; WB_REQ = 1;
        tick(); chk_st("stop_ex", P_EX, E_EX);
        STOP = 0;
        tick(); chk_st("stop_wb", P_WB, E_WB);
        WB_REQ = 0;
        tick(); exp_cnt = 3; chk_st("stop_idle", P_IDLE, E_NONE);
        tick(); chk_st("stop_idle2", P_IDLE, E_NONE);

        // Single step with STEP held: one instruction, then re-sampled in IDLE.
        STEP = 1;
        tick(); chk_st("step_ft", P_FT, E_FT);
        tick(); chk_st("step_dc", P_DC, E_DC);
        tick(); chk_st("step_ex", P_EX, E_EX);
        tick(); exp_cnt = 4; chk_st("step_idle", P_IDLE, E_NONE);
        tick(); chk_st("step_ft2", P_FT, E_FT);
        STEP = 0;
        tick(); chk_st("step_dc2", P_DC, E_DC);
        tick(); chk_st("step_ex2", P_EX, E_EX);
        tick(); exp_cnt = 5; chk_st("step_idle2", P_IDLE, E_NONE);

        // Memory wait: 3 wait cycles stretch FT to 4 cycles.
        STEP = 1; MEM_RDY = 0;
        tick(); chk_st("wait_ft0", P_FT, E_FT);
        STEP = 0;
        for (int i = 1; i < 4; i++) begin
            tick(); chk_st($sformatf("wait_ft%0d", i), P_FT, E_FT);
        end
        MEM_RDY = 1;
        tick(); chk_st("wait_dc", P_DC, E_DC);
        tick(); chk_st("wait_ex", P_EX, E_EX);
        tick(); exp_cnt = 6; chk_st("wait_idle", P_IDLE, E_NONE);

        // HALT: counts, ignores RUN/STEP/STOP, leaves on CLR_HALT.
        RUN = 1;
        tick(); chk_st("halt_ft", P_FT, E_FT);
        tick(); chk_st("halt_dc", P_DC, E_DC);
        HALT_REQ = 1; WB_REQ = 1;
        tick(); chk_st("halt_ex", P_EX, E_EX);
        tick(); exp_cnt = 7; chk_st("halt_in", P_HALT, E_NONE);
        HALT_REQ = 0; WB_REQ = 0; STEP = 1; STOP = 1;
        tick(); chk_st("halt_hold", P_HALT, E_NONE);
        STOP = 0;
        tick(); chk_st("halt_hold2", P_HALT, E_NONE);
        CLR_HALT = 1;
        tick(); chk_st("halt_clr", P_IDLE, E_NONE);
        CLR_HALT = 0; RUN = 0; STEP = 0;
        tick(); chk_st("halt_idle", P_IDLE, E_NONE);

        // Asynchronous reset mid-DC: enables drop before the next edge.
        STEP = 1;
        tick(); chk_st("ar_ft", P_FT, E_FT);
        STEP = 0;
        tick(); chk_st("ar_dc", P_DC, E_DC);
        #2 RST = 1'b1;
        #1 exp_cnt = 0; chk_st("ar_async", P_IDLE, E_NONE);
        #1 RST = 1'b0;
        tick(); chk_st("ar_after", P_IDLE, E_NONE);

        // Back-to-back run to cross the 4-bit wrap point (15 -> 0).
        RUN = 1; MEM_RDY = 1; WB_REQ = 0;
        tick(); chk_st("wrap_ft", P_FT, E_FT);
        for (int n = 1; n <= 17; n++) begin
            tick();
            tick();
            tick();
            exp_cnt = n;
            chk_st($sformatf("wrap%0d", n), P_FT, E_FT);
        end
        RUN = 0; STOP = 1;
        tick(); chk_st("wrap_dc", P_DC, E_DC);
        STOP = 0;
        tick(); chk_st("wrap_ex", P_EX, E_EX);
        tick(); exp_cnt = 18; chk_st("wrap_idle", P_IDLE, E_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
